instr_fetch_buffer: RTL and testbench
=====================================

Name: instr_fetch_buffer

Overview:
- Instruction-fetch stage and IF/ID buffer. Generates fetch addresses to a synchronous instruction memory and holds the fetched instruction in the 16-bit buffer that drives the control unit's instruction input.
- Honours the hazard stall from the hazard unit and the branch redirect (pc_src plus target) returned from decode/execute.
- Inserts NOP bubbles on redirect and reports the PC of each buffered instruction.

Parameters:
- PC_W, 16, width of PC and instruction-memory address.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP_INSTR, 16'h0000, encoding placed in the buffer when it is invalid or flushed.

Ports:
- CLOCK  input  1  system clock, rising-edge.
- in_rst  input  1  asynchronous active-low reset.
- in_hz  input  1  hazard stall; 1 = hold buffer and PC.
- in_pc_src  input  1  branch/jump taken; 1 = redirect fetch.
- in_branch_target  input  PC_W  redirect address, sampled when in_pc_src=1.
- in_imem_data  input  INSTR_W  instruction-memory read data; valid one cycle after address/enable.
- out_imem_addr  output  PC_W  instruction-memory read address.
- out_imem_en  output  1  instruction-memory read enable.
- out_buf  output  INSTR_W  IF/ID instruction to the control unit.
- out_buf_valid  output  1  out_buf holds a real instruction.
- out_buf_pc  output  PC_W  address of the instruction in out_buf.
- out_flush_cnt  output  8  saturating count of redirects taken.

Behaviour:
- Reset (in_rst=0, asynchronous):
  - state=S_RESET, PC=RESET_PC, out_imem_addr=RESET_PC, out_imem_en=0.
  - out_buf=NOP_INSTR, out_buf_valid=0, out_buf_pc=0, out_flush_cnt=0, internal pending flag=0.
  - Reset asserted mid-operation discards all in-flight fetches.
- State machine:
  - S_RESET -> S_RUN on the first edge after reset release. On that edge: out_imem_en=1, out_imem_addr=RESET_PC, pending=1.
  - S_RUN, each edge, in priority order:
    - in_pc_src=1 -> S_REDIRECT.
    - else in_hz=1 -> S_STALL.
    - else:
      - If pending=1: out_buf<=in_imem_data, out_buf_valid<=1, out_buf_pc<=out_imem_addr.
      - Then out_imem_addr<=out_imem_addr+1 (wraps 16'hFFFF->16'h0000), pending=1.
  - S_STALL: every edge with in_hz=1 holds out_buf, out_buf_valid, out_buf_pc and out_imem_addr; out_imem_en stays 1, so memory re-reads the same address and data stays stable.
    - in_hz=0 with in_pc_src=0 -> S_RUN behaviour applies on that same edge: capture, then advance.
    - in_pc_src=1 -> S_REDIRECT.
  - S_REDIRECT (entered on the edge where in_pc_src=1, from S_RUN or S_STALL):
    - On that edge: out_imem_addr<=in_branch_target, out_buf<=NOP_INSTR, out_buf_valid<=0, out_flush_cnt<=out_flush_cnt+1 saturating at 255. The in-flight wrong-path instruction is discarded.
    - Next edge: captures mem[target] into out_buf (valid=1, out_buf_pc=target), issues target+1, returns to S_RUN.
    - If in_hz=1 on that next edge, go to S_STALL without capture; buffer stays NOP/invalid.
- Priority: in_pc_src overrides in_hz on the same edge. in_pc_src arriving while in S_REDIRECT re-redirects to the new target and counts again.
- Latency:
  - Reset release to first valid out_buf: 2 edges.
  - Branch penalty: exactly 1 bubble cycle.
  - Stall: zero lost instructions.
- out_buf is registered only; there is no combinational path from in_imem_data to out_buf.

Test Plan:
- Reset release with memory mem[i]=16'h0100+i -> out_buf_valid=0 at edge 1; at edge 2 out_buf=16'h0100, out_buf_pc=0; one instruction per edge thereafter (16'h0101, 16'h0102, ...).
- in_hz=1 for 3 edges while out_buf=16'h0102 -> out_buf, out_buf_pc=2 and out_imem_addr=3 held for 3 edges; next edge out_buf=16'h0103, no skip or duplicate.
- in_pc_src=1, in_branch_target=16'h0040 while out_buf=16'h0104 -> next cycle out_buf=NOP, valid=0, out_flush_cnt=1; following cycle out_buf=mem[0x40], out_buf_pc=16'h0040.
- in_pc_src=1 and in_hz=1 on the same edge -> redirect taken, buffer flushed to NOP, PC moves to the target.
- Target 16'hFFFE, run 4 edges -> out_buf_pc sequence FFFE, FFFF, 0000, 0001.
- 300 redirects -> out_flush_cnt stops at 255. Assert in_rst=0 mid-stall -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_buffer_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and
// the IF/ID buffer outputs. The fetch stage uses 'slave'; its environment uses 'master'.
interface instr_fetch_buffer_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               in_hz;
  logic               in_pc_src;
  logic [PC_W-1:0]    in_branch_target;
  logic [INSTR_W-1:0] in_imem_data;
  logic [PC_W-1:0]    out_imem_addr;
  logic               out_imem_en;
  logic [INSTR_W-1:0] out_buf;
  logic               out_buf_valid;
  logic [PC_W-1:0]    out_buf_pc;
  logic [7:0]         out_flush_cnt;

  modport slave (
    input  in_hz, in_pc_src, in_branch_target, in_imem_data,
    output out_imem_addr, out_imem_en, out_buf, out_buf_valid, out_buf_pc, out_flush_cnt
  );

  modport master (
    output in_hz, in_pc_src, in_branch_target, in_imem_data,
    input  out_imem_addr, out_imem_en, out_buf, out_buf_valid, out_buf_pc, out_flush_cnt
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage with IF/ID buffer: drives a synchronous instruction
// memory, honours hazard stalls and branch redirects, counts flushes.
module instr_fetch_buffer #(
  parameter int              PC_W      = 16,
  parameter int              INSTR_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
  input logic                   CLOCK,
  input logic                   in_rst,
  instr_fetch_buffer_if.slave   bus
);

  localparam logic [1:0] S_RESET    = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_STALL    = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]         state_q,   state_d;
  logic [PC_W-1:0]    addr_q,    addr_d;
  logic               en_q,      en_d;
  logic [INSTR_W-1:0] buf_q,     buf_d;
  logic               valid_q,   valid_d;
  logic [PC_W-1:0]    buf_pc_q,  buf_pc_d;
  logic [7:0]         flush_q,   flush_d;
  logic               pending_q, pending_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    en_d      = en_q;
    buf_d     = buf_q;
    valid_d   = valid_q;
    buf_pc_d  = buf_pc_q;
    flush_d   = flush_q;
    pending_d = pending_q;
    case (state_q)
      S_RESET: begin
        state_d   = S_RUN;
        en_d      = 1'b1;
        addr_d    = RESET_PC;
        pending_d = 1'b1;
      end
      S_RUN, S_STALL, S_REDIRECT: begin
        // Redirect wins over stall; the wrong-path word on the memory bus is dropped.
        if (bus.in_pc_src) begin
          state_d   = S_REDIRECT;
          addr_d    = bus.in_branch_target;
          buf_d     = NOP_INSTR;
          valid_d   = 1'b0;
          flush_d   = (flush_q == 8'hFF) ? flush_q : flush_q + 8'd1;
          pending_d = 1'b1;
        end else if (bus.in_hz) begin
          state_d = S_STALL;
        end else begin
          state_d = S_RUN;
          if (pending_q) begin
            buf_d    = bus.in_imem_data;
            valid_d  = 1'b1;
            buf_pc_d = addr_q;
          end
          addr_d    = addr_q + 1'b1;
          pending_d = 1'b1;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge CLOCK or negedge in_rst) begin
    if (!in_rst) begin
      state_q   <= S_RESET;
      addr_q    <= RESET_PC;
      en_q      <= 1'b0;
      buf_q     <= NOP_INSTR;
      valid_q   <= 1'b0;
      buf_pc_q  <= '0;
      flush_q   <= 8'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      buf_q     <= buf_d;
      valid_q   <= valid_d;
      buf_pc_q  <= buf_pc_d;
      flush_q   <= flush_d;
      pending_q <= pending_d;
    end
  end

  assign bus.out_imem_addr = addr_q;
  assign bus.out_imem_en   = en_q;
  assign bus.out_buf       = buf_q;
  assign bus.out_buf_valid = valid_q;
  assign bus.out_buf_pc    = buf_pc_q;
  assign bus.out_flush_cnt = flush_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: directed scenarios plus random
// stall/redirect traffic checked against a rule-level fetch model.
module tb_instr_fetch_buffer;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  instr_fetch_buffer_if #(.PC_W(16), .INSTR_W(16)) bus ();

  instr_fetch_buffer #(
    .PC_W(16), .INSTR_W(16), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)
  ) dut (
    .CLOCK (clk),
    .in_rst(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h0100 + a;
  endfunction

  // Memory read data follows the registered fetch address held in the DUT.
  assign bus.in_imem_data = mem_word(bus.out_imem_addr);

  // Reference model state
  bit          m_run;
  logic        m_en;
  logic [15:0] m_addr;
  logic [15:0] m_buf;
  logic        m_valid;
  logic [15:0] m_pc;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_en = 1'b0; m_addr = RESET_PC; m_buf = NOP_INSTR;
    m_valid = 1'b0; m_pc = 16'h0000; m_cnt = 0;
  endtask

  task automatic model_step(input logic hz, input logic ps, input logic [15:0] tgt);
    if (!m_run) begin
      m_run = 1; m_en = 1'b1; m_addr = RESET_PC;
    end else if (ps) begin
      m_addr = tgt; m_buf = NOP_INSTR; m_valid = 1'b0;
      if (m_cnt < 255) m_cnt++;
    end else if (!hz) begin
      m_buf = mem_word(m_addr); m_valid = 1'b1; m_pc = m_addr; m_addr = m_addr + 16'd1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".buf"},   32'(bus.out_buf),       32'(m_buf));
    check_eq({tag, ".valid"}, 32'(bus.out_buf_valid), 32'(m_valid));
    check_eq({tag, ".pc"},    32'(bus.out_buf_pc),    32'(m_pc));
    check_eq({tag, ".addr"},  32'(bus.out_imem_addr), 32'(m_addr));
    check_eq({tag, ".en"},    32'(bus.out_imem_en),   32'(m_en));
    check_eq({tag, ".cnt"},   32'(bus.out_flush_cnt), 32'(m_cnt));
  endtask

  task automatic cycle(input string tag, input logic hz, input logic ps, input logic [15:0] tgt);
    bus.in_hz = hz; bus.in_pc_src = ps; bus.in_branch_target = tgt;
    @(posedge clk);
    model_step(hz, ps, tgt);
    @(negedge clk);
    check_outputs(tag);
    $display("cycle %-6s hz=%0b ps=%0b tgt=%h -> buf=%h v=%0b pc=%h addr=%h cnt=%0d",
             tag, hz, ps, tgt, bus.out_buf, bus.out_buf_valid, bus.out_buf_pc,
             bus.out_imem_addr, bus.out_flush_cnt);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".buf"},   32'(bus.out_buf),       32'(NOP_INSTR));
    check_eq({tag, ".valid"}, 32'(bus.out_buf_valid), 32'd0);
    check_eq({tag, ".pc"},    32'(bus.out_buf_pc),    32'd0);
    check_eq({tag, ".addr"},  32'(bus.out_imem_addr), 32'(RESET_PC));
    check_eq({tag, ".en"},    32'(bus.out_imem_en),   32'd0);
    check_eq({tag, ".cnt"},   32'(bus.out_flush_cnt), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.in_hz = 1'b0; bus.in_pc_src = 1'b0; bus.in_branch_target = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Startup: bubble on edge 1, first instruction on edge 2
    cycle("e1", 0, 0, 0);
    cycle("e2", 0, 0, 0);
    check_eq("first_buf", 32'(bus.out_buf), 32'h0100);
    cycle("run", 0, 0, 0);
    cycle("run", 0, 0, 0);
    check_eq("buf_0102", 32'(bus.out_buf), 32'h0102);

    // Three-edge stall, then resume without skip or duplicate
    for (int i = 0; i < 3; i++) cycle("stall", 1, 0, 0);
    check_eq("stall_addr", 32'(bus.out_imem_addr), 32'h0003);
    cycle("resume", 0, 0, 0);
    check_eq("resume_buf", 32'(bus.out_buf), 32'h0103);
    cycle("run", 0, 0, 0);

    // Redirect to 0x0040: one bubble then mem[0x40]
    cycle("br", 0, 1, 16'h0040);
    check_eq("br_flush", 32'(bus.out_flush_cnt), 32'd1);
    cycle("brtgt", 0, 0, 0);
    check_eq("br_pc", 32'(bus.out_buf_pc), 32'h0040);

    // Redirect and stall on the same edge: redirect wins
    cycle("brhz", 1, 1, 16'h0080);
    check_eq("brhz_addr", 32'(bus.out_imem_addr), 32'h0080);
    cycle("hz_red", 1, 0, 0);
    cycle("run", 0, 0, 0);

    // Address wrap
    cycle("wrap", 0, 1, 16'hFFFE);
    for (int i = 0; i < 4; i++) cycle("wrap", 0, 0, 0);
    check_eq("wrap_pc", 32'(bus.out_buf_pc), 32'h0001);

    // Random stalls and redirects
    for (int i = 0; i < 400; i++) begin
      logic       hz, ps;
      logic [15:0] tgt;
      hz  = ($urandom_range(0, 3) == 0);
      ps  = ($urandom_range(0, 9) == 0);
      tgt = 16'($urandom_range(0, 65535));
      cycle("rand", hz, ps, tgt);
    end

    // Flush counter saturation
    for (int i = 0; i < 300; i++) cycle("sat", 0, 1, 16'($urandom_range(0, 65535)));
    check_eq("sat_cnt", 32'(bus.out_flush_cnt), 32'd255);

    // Asynchronous reset in the middle of a stall
    cycle("stall", 1, 0, 0);
    cycle("stall", 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("arst");
    $display("cycle arst   reset asserted between edges");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_hz = 1'b0; bus.in_pc_src = 1'b0;
    cycle("re1", 0, 0, 0);
    cycle("re2", 0, 0, 0);
    check_eq("re_buf", 32'(bus.out_buf), 32'h0100);
    for (int i = 0; i < 50; i++)
      cycle("rand2", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            16'($urandom_range(0, 65535)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
